// File: rtl/vmem_access_unit.sv
// Vector load/store sequencer in front of a 6-lane data memory; partial stores use read-modify-write.
// Optional address range check is enabled by defining VMEM_ADDR_CHECK_EN.
module vmem_access_unit #(
    parameter int unsigned DMEM_SIZE = 10926,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned LANES     = 6,
    parameter int unsigned LANE_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [LANES*LANE_W-1:0]  req_wdata,
    input  logic [LANES-1:0]         req_mask,
    output logic                     resp_valid,
    output logic [LANES*LANE_W-1:0]  resp_rdata,
    output logic                     resp_err,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_we,
    output logic [LANES*LANE_W-1:0]  mem_wd,
    input  logic [LANES*LANE_W-1:0]  mem_rd
);

    localparam int unsigned DATA_W = LANES * LANE_W;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

`ifdef VMEM_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LANES-1:0]  mask_q;
    logic              we_q;
    logic [DATA_W-1:0] rbuf_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] mem_a_q;

    logic              accept;
    logic              addr_fault;
    logic [DATA_W-1:0] merged_wd;

    assign req_ready  = rst_n & (state_q == StIdle);
    assign accept     = req_valid & req_ready;
    assign addr_fault = ADDR_CHECK && (req_addr > ADDR_W'(DMEM_SIZE));

    // Lanes not enabled by the mask keep the value read back in the READ state.
    always_comb begin
        merged_wd = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            merged_wd[i*LANE_W +: LANE_W] = mask_q[i] ? wdata_q[i*LANE_W +: LANE_W]
                                                      : rbuf_q[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (addr_fault) begin
                        state_d = StDone;
                    end else if (!req_we) begin
                        state_d = StRead;
                    end else if (&req_mask) begin
                        state_d = StWrite;
                    end else if (req_mask == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = we_q ? StWrite : StDone;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mem_a_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mask_q  <= req_mask;
                we_q    <= req_we;
            end
            // mem_a only moves when the memory is actually going to be accessed.
            if (accept && (state_d == StRead || state_d == StWrite)) begin
                mem_a_q <= req_addr;
            end
            if (state_q == StRead) begin
                rbuf_q <= mem_rd;
            end
            if (state_d == StDone) begin
                err_q <= 1'b0;
                case (state_q)
                    StIdle: begin
                        rdata_q <= addr_fault ? '0 : rbuf_q;
                        err_q   <= addr_fault;
                    end
                    StRead:  rdata_q <= mem_rd;
                    StWrite: rdata_q <= merged_wd;
                    default: rdata_q <= rdata_q;
                endcase
            end
        end
    end

    assign resp_valid = rst_n & (state_q == StDone);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_a      = mem_a_q;
    assign mem_we     = rst_n & (state_q == StWrite);
    assign mem_wd     = mem_we ? merged_wd : '0;

endmodule
